// File: rtl/arm_shift_unit.sv
// Iterative ARM register-controlled shifter (LSL/LSR/ASR/ROR/RRX).
// Shifts at most CHUNK bit positions per cycle and reports through a start/done handshake.
module arm_shift_unit #(
  parameter int CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  shift_type,
  input  logic        rrx,
  input  logic [31:0] amount,
  input  logic [31:0] value,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        carry_out
);

  // Handshake: start is accepted only in IDLE or DONE (ignored in SHIFT, never
  // queued); done is high for exactly the cycle result/carry_out become valid,
  // and both hold until the next accepted start reaches DONE.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int KW = $clog2(CHUNK + 1);

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [5:0]  rem_q, rem_d;
  logic [31:0] word_q, word_d;
  logic        fill_q, fill_d;
  logic        cin_q, cin_d;
  logic [1:0]  op_q, op_d;
  logic        rrx_q, rrx_d;
  logic [31:0] result_q, result_d;
  logic        carry_out_q, carry_out_d;

  logic [7:0]  amt8;
  logic [5:0]  eff;
  logic        unused_amount_hi;

  logic [KW-1:0] k;
  logic [32:0]   lsl_full;
  logic [32:0]   lsr_full;
  logic [31:0]   asr_mask;
  logic [31:0]   ror_word;
  logic [31:0]   step_word;
  logic          step_carry;
  logic [5:0]    rem_next;

  assign amt8             = amount[7:0];
  assign unused_amount_hi = ^amount[31:8];

  // Effective amount: saturate where further shifting cannot change the outcome.
  always_comb begin
    eff = 6'd0;
    case (shift_type)
      OP_LSL, OP_LSR: eff = (amt8 > 8'd33) ? 6'd33 : amt8[5:0];
      OP_ASR:         eff = (amt8 > 8'd32) ? 6'd32 : amt8[5:0];
      default: begin
        if (rrx)                  eff = 6'd1;
        else if (amt8 == 8'd0)    eff = 6'd0;
        else if (amt8[4:0] == 5'd0) eff = 6'd32;
        else                      eff = {1'b0, amt8[4:0]};
      end
    endcase
  end

  // One SHIFT step of k positions; the extra bit in the 33-bit forms is the
  // last bit shifted out, which becomes the carry.
  always_comb begin
    k          = (rem_q > 6'(CHUNK)) ? KW'(CHUNK) : KW'(rem_q);
    lsl_full   = {1'b0, word_q} << k;
    lsr_full   = {word_q, 1'b0} >> k;
    asr_mask   = fill_q ? ~({32{1'b1}} >> k) : 32'd0;
    ror_word   = (word_q >> k) | (word_q << (6'd32 - 6'(k)));
    step_word  = word_q;
    step_carry = 1'b0;
    if (rrx_q) begin
      step_word  = {cin_q, word_q[31:1]};
      step_carry = word_q[0];
    end else begin
      case (op_q)
        OP_LSL: begin
          step_word  = lsl_full[31:0];
          step_carry = lsl_full[32];
        end
        OP_LSR: begin
          step_word  = lsr_full[32:1];
          step_carry = lsr_full[0];
        end
        OP_ASR: begin
          step_word  = lsr_full[32:1] | asr_mask;
          step_carry = lsr_full[0];
        end
        default: begin
          step_word  = ror_word;
          step_carry = ror_word[31];
        end
      endcase
    end
    rem_next = rem_q - 6'(k);
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    word_d      = word_q;
    fill_d      = fill_q;
    cin_d       = cin_q;
    op_d        = op_q;
    rrx_d       = rrx_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          word_d = value;
          fill_d = value[31];
          cin_d  = carry_in;
          op_d   = shift_type;
          rrx_d  = rrx && (shift_type == 2'b11);
          rem_d  = eff;
          if (eff == 6'd0) begin
            state_d     = ST_DONE;
            result_d    = value;
            carry_out_d = carry_in;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        word_d = step_word;
        rem_d  = rem_next;
        if (rem_next == 6'd0) begin
          state_d     = ST_DONE;
          result_d    = step_word;
          carry_out_d = step_carry;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rem_q       <= 6'd0;
      word_q      <= 32'd0;
      fill_q      <= 1'b0;
      cin_q       <= 1'b0;
      op_q        <= 2'b00;
      rrx_q       <= 1'b0;
      result_q    <= 32'd0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      word_q      <= word_d;
      fill_q      <= fill_d;
      cin_q       <= cin_d;
      op_q        <= op_d;
      rrx_q       <= rrx_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign busy      = (state_q == ST_SHIFT);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_arm_shift_unit.sv
// Directed-vector bench for arm_shift_unit: data, carry, latency and handshake.
module tb_arm_shift_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  shift_type;
  logic        rrx;
  logic [31:0] amount;
  logic [31:0] value;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;

  int n_cmp;
  int n_err;

  arm_shift_unit #(.CHUNK(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .shift_type (shift_type),
    .rrx        (rrx),
    .amount     (amount),
    .value      (value),
    .carry_in   (carry_in),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .carry_out  (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation, scramble inputs afterwards, and measure latency/busy.
  // lat counts cycles after T+1 until done; done in cycle T+1+lat.
  task automatic run_op(input logic [1:0] st, input logic rx, input logic [31:0] amt,
                        input logic [31:0] val, input logic cin,
                        output logic [31:0] res, output logic co,
                        output int lat, output int bc);
    @(negedge clk);
    shift_type = st; rrx = rx; amount = amt; value = val; carry_in = cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    value = $urandom; amount = $urandom; carry_in = 1'($urandom_range(0, 1));
    shift_type = 2'($urandom_range(0, 3)); rrx = 1'($urandom_range(0, 1));
    lat = 0;
    bc  = 0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    res = result;
    co  = carry_out;
  endtask

  task automatic test_reset;
    logic [31:0] res; logic co; int lat; int bc; int seen;
    shift_type = 2'b00; rrx = 1'b0; amount = 32'd0; value = 32'd0; carry_in = 1'b0;
    start = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, result, carry_out} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_init got busy=%b done=%b result=%h carry=%b want all 0", busy, done, result, carry_out);
    end
    rst_n = 1'b1;
    run_op(2'b00, 1'b0, 32'd4, 32'h1, 1'b0, res, co, lat, bc);
    @(negedge clk);
    shift_type = 2'b00; amount = 32'd33; value = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, result, carry_out} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_mid got busy=%b done=%b result=%h carry=%b want all 0", busy, done, result, carry_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL reset_abort got %0d busy/done cycles want 0", seen);
    end
    run_op(2'b00, 1'b0, 32'd4, 32'h1, 1'b0, res, co, lat, bc);
    n_cmp++;
    if ({co, res} !== {1'b0, 32'h10}) begin
      n_err++;
      $display("FAIL reset_lsl4_data got c=%b r=%h want c=0 r=00000010", co, res);
    end
    n_cmp++;
    if (lat !== 1 || bc !== 1) begin
      n_err++;
      $display("FAIL reset_lsl4_timing got lat=%0d busy=%0d want 1/1", lat, bc);
    end
  endtask

  task automatic test_lsl_lsr;
    logic [31:0] res; logic co; int lat; int bc;
    logic [1:0]  v_st  [6] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
    logic [31:0] v_amt [6] = '{32'd32, 32'd40, 32'd33, 32'd32, 32'd31, 32'd12};
    logic [31:0] v_val [6] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 32'h3, 32'h800};
    logic [31:0] v_res [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h8000_0000, 32'h0};
    logic        v_co  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int          v_n   [6] = '{4, 5, 5, 4, 4, 2};
    for (int i = 0; i < 6; i++) begin
      run_op(v_st[i], 1'b0, v_amt[i], v_val[i], 1'b0, res, co, lat, bc);
      n_cmp++;
      if ({co, res} !== {v_co[i], v_res[i]}) begin
        n_err++;
        $display("FAIL lsl_lsr_data[%0d] got c=%b r=%h want c=%b r=%h", i, co, res, v_co[i], v_res[i]);
      end
      n_cmp++;
      if (lat !== v_n[i] || bc !== v_n[i]) begin
        n_err++;
        $display("FAIL lsl_lsr_timing[%0d] got lat=%0d busy=%0d want %0d", i, lat, bc, v_n[i]);
      end
    end
  endtask

  task automatic test_asr_ror;
    logic [31:0] res; logic co; int lat; int bc;
    logic [1:0]  v_st  [6] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11};
    logic [31:0] v_amt [6] = '{32'hC8, 32'hFFFF_FF05, 32'd33, 32'd4, 32'd64, 32'd1};
    logic [31:0] v_val [6] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'hF1, 32'hF1, 32'h8000_0001};
    logic [31:0] v_res [6] = '{32'hFFFF_FFFF, 32'hFC00_0000, 32'h0, 32'h1000_000F, 32'hF1, 32'hC000_0000};
    logic        v_co  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          v_n   [6] = '{4, 1, 4, 1, 4, 1};
    for (int i = 0; i < 6; i++) begin
      run_op(v_st[i], 1'b0, v_amt[i], v_val[i], 1'b1, res, co, lat, bc);
      n_cmp++;
      if ({co, res} !== {v_co[i], v_res[i]}) begin
        n_err++;
        $display("FAIL asr_ror_data[%0d] got c=%b r=%h want c=%b r=%h", i, co, res, v_co[i], v_res[i]);
      end
      n_cmp++;
      if (lat !== v_n[i] || bc !== v_n[i]) begin
        n_err++;
        $display("FAIL asr_ror_timing[%0d] got lat=%0d busy=%0d want %0d", i, lat, bc, v_n[i]);
      end
    end
  endtask

  task automatic test_rrx_zero;
    logic [31:0] res; logic co; int lat; int bc;
    run_op(2'b11, 1'b1, 32'd77, 32'h3, 1'b1, res, co, lat, bc);
    n_cmp++;
    if ({co, res} !== {1'b1, 32'h8000_0001} || lat !== 1 || bc !== 1) begin
      n_err++;
      $display("FAIL rrx got c=%b r=%h lat=%0d busy=%0d want c=1 r=80000001 lat=1 busy=1", co, res, lat, bc);
    end
    run_op(2'b00, 1'b0, 32'h0000_0100, 32'h1234_5678, 1'b1, res, co, lat, bc);
    n_cmp++;
    if ({co, res} !== {1'b1, 32'h1234_5678} || lat !== 0 || bc !== 0) begin
      n_err++;
      $display("FAIL lsl_zero got c=%b r=%h lat=%0d busy=%0d want c=1 r=12345678 lat=0 busy=0", co, res, lat, bc);
    end
    run_op(2'b11, 1'b0, 32'd0, 32'hCAFE_0000, 1'b0, res, co, lat, bc);
    n_cmp++;
    if ({co, res} !== {1'b0, 32'hCAFE_0000} || lat !== 0 || bc !== 0) begin
      n_err++;
      $display("FAIL ror_zero got c=%b r=%h lat=%0d busy=%0d want c=0 r=cafe0000 lat=0 busy=0", co, res, lat, bc);
    end
  endtask

  task automatic test_ignored_start;
    @(negedge clk);
    shift_type = 2'b01; rrx = 1'b0; amount = 32'd16; value = 32'hABCD_0000; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    shift_type = 2'b00; amount = 32'd0; value = 32'h0000_DEAD; carry_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL ignored_start_busy got busy=%b done=%b want 1/0", busy, done);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, carry_out, result} !== {1'b1, 1'b0, 32'h0000_ABCD}) begin
      n_err++;
      $display("FAIL ignored_start_result got done=%b c=%b r=%h want 1/0/0000abcd", done, carry_out, result);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, busy, result} !== {2'b00, 32'h0000_ABCD}) begin
      n_err++;
      $display("FAIL ignored_start_idle got done=%b busy=%b r=%h want 0/0/0000abcd", done, busy, result);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    shift_type = 2'b11; rrx = 1'b0; amount = 32'd4; value = 32'hF1; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    shift_type = 2'b00; amount = 32'd8; value = 32'h1; carry_in = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first_busy got %b want 1", busy);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, carry_out, result} !== {1'b1, 1'b0, 32'h1000_000F}) begin
      n_err++;
      $display("FAIL b2b_first_done got done=%b c=%b r=%h want 1/0/1000000f", done, carry_out, result);
    end
    @(negedge clk);
    amount = 32'd0; value = 32'h55; carry_in = 1'b1;
    n_cmp++;
    if ({done, busy, result} !== {2'b01, 32'h1000_000F}) begin
      n_err++;
      $display("FAIL b2b_hold got done=%b busy=%b r=%h want 0/1/1000000f", done, busy, result);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, carry_out, result} !== {1'b1, 1'b0, 32'h0000_0100}) begin
      n_err++;
      $display("FAIL b2b_second_done got done=%b c=%b r=%h want 1/0/00000100", done, carry_out, result);
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({done, busy, carry_out, result} !== {3'b101, 32'h0000_0055}) begin
      n_err++;
      $display("FAIL b2b_zero_done got done=%b busy=%b c=%b r=%h want 1/0/1/00000055", done, busy, carry_out, result);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_end got done=%b want 0", done);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset;
    test_lsl_lsr;
    test_asr_ror;
    test_rrx_zero;
    test_ignored_start;
    test_back_to_back;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
